// File: rtl/alg_seq_pkg.sv
// rtl/alg_seq_pkg.sv - shared types and defaults for the ECG core sequencer
package alg_seq_pkg;

    localparam int DEF_CLK_DIV    = 100000;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_SAMPLE_W   = 11;
    localparam int DEF_RR_W       = 16;
    localparam int DEF_PEAK_W     = 32;

    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_ISSUE     = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alg_sample_fifo.sv
// rtl/alg_sample_fifo.sv - synchronous sample FIFO with extra-bit wrap pointers
module alg_sample_fifo
    import alg_seq_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int WIDTH = DEF_SAMPLE_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers share the address bits when full or empty; the MSB tells them apart.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alg_core_sequencer.sv
// rtl/alg_core_sequencer.sv - sample-rate scheduler and R-peak result collector for alg_core
module alg_core_sequencer
    import alg_seq_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int RR_W       = DEF_RR_W,
    parameter int PEAK_W     = DEF_PEAK_W
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                core_ce,
    output logic [SAMPLE_W-1:0] core_ecg_value,
    output logic                core_data_valid,
    input  logic [RR_W-1:0]     core_rr_period,
    input  logic [PEAK_W-1:0]   core_r_peak_sample_num,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RR_W-1:0]     res_rr_period,
    output logic [PEAK_W-1:0]   res_peak_num,
    output logic [7:0]          underrun_cnt,
    output logic                overrun
);

    localparam int               CNT_W   = $clog2(CLK_DIV);
    localparam int               AW      = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    seq_state_t          state;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         fifo_level;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic [PEAK_W-1:0]   prev_peak;
    logic                new_result;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign tick      = enable && (state != ST_IDLE) && (tick_cnt == CNT_MAX);
    assign fifo_pop  = enable && (state == ST_WAIT_TICK) && tick && !fifo_empty;

    alg_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (fifo_push),
        .wdata (in_sample),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The period counter keeps running through ISSUE so strobes stay exactly CLK_DIV apart.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt <= '0;
        end else if (!enable || state == ST_IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= ST_IDLE;
            core_ce         <= 1'b0;
            core_data_valid <= 1'b0;
            core_ecg_value  <= '0;
            underrun_cnt    <= '0;
        end else begin
            core_data_valid <= 1'b0;
            if (!enable) begin
                state   <= ST_IDLE;
                core_ce <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_WAIT_TICK;
                        core_ce <= 1'b1;
                    end
                    ST_WAIT_TICK: begin
                        if (fifo_pop) begin
                            state           <= ST_ISSUE;
                            core_ecg_value  <= fifo_rdata;
                            core_data_valid <= 1'b1;
                        end else if (tick && underrun_cnt != UNDERRUN_MAX) begin
                            underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                    ST_ISSUE: begin
                        state <= ST_WAIT_TICK;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        core_ce <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The core has no result strobe; a change of the peak index marks a fresh result.
    assign new_result = core_ce && (core_r_peak_sample_num != prev_peak);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_peak     <= '0;
            res_valid     <= 1'b0;
            res_rr_period <= '0;
            res_peak_num  <= '0;
            overrun       <= 1'b0;
        end else begin
            prev_peak <= core_r_peak_sample_num;
            if (new_result) begin
                res_rr_period <= core_rr_period;
                res_peak_num  <= core_r_peak_sample_num;
                res_valid     <= 1'b1;
                if (res_valid && !res_ready) overrun <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    a_level_matches_empty: assert property (@(posedge clk) disable iff (!nrst)
        (fifo_level == '0) == fifo_empty);

endmodule

// File: tb/tb_alg_core_sequencer.sv
// tb/tb_alg_core_sequencer.sv - directed self-checking bench for alg_core_sequencer
module tb_alg_core_sequencer;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] in_sample = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        core_ce;
    logic [10:0] core_ecg_value;
    logic        core_data_valid;
    logic [15:0] core_rr_period = '0;
    logic [31:0] core_r_peak_sample_num = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_rr_period;
    logic [31:0] res_peak_num;
    logic [7:0]  underrun_cnt;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    alg_core_sequencer #(
        .CLK_DIV(10), .FIFO_DEPTH(8), .SAMPLE_W(11), .RR_W(16), .PEAK_W(32)
    ) dut (
        .clk(clk), .nrst(nrst), .enable(enable),
        .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
        .core_ce(core_ce), .core_ecg_value(core_ecg_value), .core_data_valid(core_data_valid),
        .core_rr_period(core_rr_period), .core_r_peak_sample_num(core_r_peak_sample_num),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_rr_period(res_rr_period), .res_peak_num(res_peak_num),
        .underrun_cnt(underrun_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 nrst = 1'b0;
        step(2);
        n_checks++;
        if ({in_ready, core_ce, core_data_valid, res_valid, overrun} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 10000",
                     {in_ready, core_ce, core_data_valid, res_valid, overrun});
        end
        n_checks++;
        if ({core_ecg_value, res_rr_period, res_peak_num, underrun_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: got %h/%h/%h/%h expected all zero",
                     core_ecg_value, res_rr_period, res_peak_num, underrun_cnt);
        end
        nrst = 1'b1;
        step(2);
    endtask

    task automatic test_steady_stream;
        logic [10:0] vals [4];
        int          idx;
        logic        exp_dv;
        vals = '{11'h001, 11'h7FF, 11'h400, 11'h123};
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_sample = vals[i];
            step(1);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step(1);
            if (k == 1) begin
                n_checks++;
                if (core_ce !== 1'b1) begin
                    n_errors++;
                    $display("FAIL stream_ce: got %b expected 1", core_ce);
                end
            end
            idx    = (k - 11) / 10;
            exp_dv = (k >= 11) && ((k - 11) % 10 == 0) && (idx < 4);
            n_checks++;
            if (core_data_valid !== exp_dv) begin
                n_errors++;
                $display("FAIL stream_dv k=%0d: got %b expected %b", k, core_data_valid, exp_dv);
            end
            if (exp_dv) begin
                n_checks++;
                if (core_ecg_value !== vals[idx]) begin
                    n_errors++;
                    $display("FAIL stream_value k=%0d: got %h expected %h", k, core_ecg_value, vals[idx]);
                end
            end
        end
        n_checks++;
        if (underrun_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL stream_underrun: got %0d expected 0", underrun_cnt);
        end
        enable = 1'b0;
        step(2);
    endtask

    task automatic test_fifo_full;
        logic        exp_dv;
        logic [10:0] exp_val;
        int          idx;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (in_ready !== (i < 8)) begin
                n_errors++;
                $display("FAIL full_ready i=%0d: got %b expected %b", i, in_ready, (i < 8));
            end
            in_valid  = 1'b1;
            in_sample = 11'h100 + 11'(i);
            step(1);
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_hold: got %b expected 0", in_ready);
        end
        enable = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            step(1);
            idx     = (k - 11) / 10;
            exp_dv  = (k >= 11) && ((k - 11) % 10 == 0) && (idx < 8);
            exp_val = 11'h100 + 11'(idx);
            n_checks++;
            if (core_data_valid !== exp_dv) begin
                n_errors++;
                $display("FAIL full_dv k=%0d: got %b expected %b", k, core_data_valid, exp_dv);
            end
            if (exp_dv) begin
                n_checks++;
                if (core_ecg_value !== exp_val) begin
                    n_errors++;
                    $display("FAIL full_value k=%0d: got %h expected %h", k, core_ecg_value, exp_val);
                end
            end
            if (k == 11) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL full_ready_after_pop: got %b expected 1", in_ready);
                end
            end
        end
        n_checks++;
        if (underrun_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL full_underrun: got %0d expected 0", underrun_cnt);
        end
        enable = 1'b0;
        step(2);
    endtask

    task automatic test_underrun;
        int strobes = 0;
        enable = 1'b1;
        for (int k = 1; k <= 3005; k++) begin
            step(1);
            if (core_data_valid === 1'b1) strobes++;
            if (k == 31) begin
                n_checks++;
                if (underrun_cnt !== 8'd3) begin
                    n_errors++;
                    $display("FAIL underrun_partial: got %0d expected 3", underrun_cnt);
                end
            end
        end
        n_checks++;
        if (strobes != 0) begin
            n_errors++;
            $display("FAIL underrun_strobes: got %0d expected 0", strobes);
        end
        n_checks++;
        if (underrun_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL underrun_saturate: got %0d expected 255", underrun_cnt);
        end
    endtask

    task automatic test_result_handshake;
        res_ready              = 1'b0;
        core_rr_period         = 16'd360;
        core_r_peak_sample_num = 32'd500;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_before: got %b expected 0", res_valid);
        end
        step(1);
        n_checks++;
        if ({res_valid, res_rr_period, res_peak_num} !== {1'b1, 16'd360, 32'd500}) begin
            n_errors++;
            $display("FAIL hs_capture: got %b/%0d/%0d expected 1/360/500", res_valid, res_rr_period, res_peak_num);
        end
        step(3);
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL hs_hold: got %b expected 1", res_valid);
        end
        res_ready = 1'b1;
        step(1);
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL hs_accept: got %b expected 0", res_valid);
        end
    endtask

    task automatic test_overrun;
        core_rr_period         = 16'd380;
        core_r_peak_sample_num = 32'd600;
        step(1);
        res_ready              = 1'b1;
        core_rr_period         = 16'd390;
        core_r_peak_sample_num = 32'd700;
        step(1);
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, res_peak_num, overrun} !== {1'b1, 32'd700, 1'b0}) begin
            n_errors++;
            $display("FAIL ovr_same_cycle: got %b/%0d/%b expected 1/700/0", res_valid, res_peak_num, overrun);
        end
        core_rr_period         = 16'd400;
        core_r_peak_sample_num = 32'd860;
        step(1);
        n_checks++;
        if ({res_valid, res_rr_period, res_peak_num, overrun} !== {1'b1, 16'd400, 32'd860, 1'b1}) begin
            n_errors++;
            $display("FAIL ovr_overwrite: got %b/%0d/%0d/%b expected 1/400/860/1",
                     res_valid, res_rr_period, res_peak_num, overrun);
        end
        step(3);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_sticky: got %b expected 1", overrun);
        end
    endtask

    task automatic test_reset_and_disable;
        int strobes = 0;
        enable = 1'b0;
        step(2);
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_sample = 11'h010 + 11'(i);
            step(1);
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        step(5);
        nrst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, core_ce, core_data_valid, res_valid, overrun} !== 5'b10000) begin
            n_errors++;
            $display("FAIL midreset_flags: got %b expected 10000",
                     {in_ready, core_ce, core_data_valid, res_valid, overrun});
        end
        n_checks++;
        if ({core_ecg_value, res_rr_period, res_peak_num, underrun_cnt} !== '0) begin
            n_errors++;
            $display("FAIL midreset_values: got %h/%h/%h/%h expected all zero",
                     core_ecg_value, res_rr_period, res_peak_num, underrun_cnt);
        end
        step(2);
        nrst = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            if (core_data_valid === 1'b1) strobes++;
        end
        n_checks++;
        if (strobes != 0) begin
            n_errors++;
            $display("FAIL midreset_strobes: got %0d expected 0", strobes);
        end
        enable = 1'b0;
        step(2);
        in_valid  = 1'b1;
        in_sample = 11'h0AA;
        step(1);
        in_sample = 11'h0BB;
        step(1);
        in_valid = 1'b0;
        enable   = 1'b1;
        step(5);
        n_checks++;
        if (core_ce !== 1'b1) begin
            n_errors++;
            $display("FAIL dis_ce_on: got %b expected 1", core_ce);
        end
        enable = 1'b0;
        step(1);
        n_checks++;
        if (core_ce !== 1'b0) begin
            n_errors++;
            $display("FAIL dis_ce_off: got %b expected 0", core_ce);
        end
        step(3);
        enable = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            n_checks++;
            if (core_data_valid !== (k == 11 || k == 21)) begin
                n_errors++;
                $display("FAIL dis_dv k=%0d: got %b expected %b", k, core_data_valid, (k == 11 || k == 21));
            end
            if (k == 11 || k == 21) begin
                n_checks++;
                if (core_ecg_value !== ((k == 11) ? 11'h0AA : 11'h0BB)) begin
                    n_errors++;
                    $display("FAIL dis_value k=%0d: got %h expected %h", k, core_ecg_value,
                             (k == 11) ? 11'h0AA : 11'h0BB);
                end
            end
        end
        enable = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_steady_stream();
        test_fifo_full();
        test_underrun();
        test_result_handshake();
        test_overrun();
        test_reset_and_disable();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
